sha_512_pad: RTL and testbench

SHA_512_PAD -- requirements
Module: sha_512_pad

---
 rtl/sha_512_pad_pkg.sv | 34 +++
 rtl/sha_512_pad_if.sv | 37 +++
 rtl/sha_512_pad.sv | 163 ++++++++++++++++
 tb/tb_sha_512_pad.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_512_pad_pkg.sv
// -----------------------------------------------------------------------------
// sha_const : shared definitions for the SHA-512 message padder.
//
// Contents
//   pad_state_t   - padder FSM state encoding (IDLE, FILL, PAD, LEN, SEND, WAIT)
//   MARKER_WORD   - the word carrying the mandatory 0x80 end-of-message byte
//                   when the message ends on a 64-bit boundary
//   LEN_HI_POS    - block word index holding length bits [127:64]
//   LEN_LO_POS    - block word index holding length bits [63:0]
//   BLOCK_WORDS   - 64-bit words per 1024-bit block
//   clamp_bytes() - final-word byte count, saturated to a full word
// -----------------------------------------------------------------------------
package sha_const;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    PAD  = 3'd2,
    LEN  = 3'd3,
    SEND = 3'd4,
    WAIT = 3'd5
  } pad_state_t;

  localparam logic [63:0] MARKER_WORD = 64'h8000_0000_0000_0000;
  localparam logic [3:0]  LEN_HI_POS  = 4'd14;
  localparam logic [3:0]  LEN_LO_POS  = 4'd15;
  localparam logic [4:0]  BLOCK_WORDS = 5'd16;

  // A final word can carry at most 8 bytes; larger counts mean "full word".
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/sha_512_pad_if.sv
// -----------------------------------------------------------------------------
// sha_512_pad_if : 64-bit message word stream into the SHA-512 padder.
//
// Signals
//   In_valid  - source has a word on In_data
//   In_ready  - padder can accept a word (transfer when both high at clk rise)
//   In_data   - message word, big-endian (first byte in [63:56])
//   In_last   - this word is the final word of the message
//   In_bytes  - valid bytes in the final word (0..8, >8 means 8)
//
// Modports
//   master - the message source
//   slave  - the padder
// -----------------------------------------------------------------------------
interface sha_512_pad_if;
  logic        In_valid;
  logic        In_ready;
  logic [63:0] In_data;
  logic        In_last;
  logic [3:0]  In_bytes;

  modport master (
    output In_valid,
    output In_data,
    output In_last,
    output In_bytes,
    input  In_ready
  );

  modport slave (
    input  In_valid,
    input  In_data,
    input  In_last,
    input  In_bytes,
    output In_ready
  );
endinterface

// File: rtl/sha_512_pad.sv
// -----------------------------------------------------------------------------
// sha_512_pad : collects a 64-bit word stream into 1024-bit SHA-512 blocks,
// appends the 0x80 marker, zero fill and 128-bit bit length, and hands each
// block to the compression core (sha_512, instantiated alongside this block).
//
// Ports
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   Start      - one-cycle pulse in IDLE starting a new message
//   Mode       - variant select (0:512/224 1:512/256 2:384 3:512), latched on Start
//   in_if      - message word stream (slave side)
//   Data       - current block, word i at Data[i*64 +: 64]
//   Index      - block number of Data (0 for the first block)
//   Operation  - latched Mode, forwarded to the core
//   Enable     - one-cycle pulse: Data/Index/Operation valid for the core
//   Ready      - core finished the current block
//   Done       - one-cycle pulse after the final block is accepted by the core
// -----------------------------------------------------------------------------
module sha_512_pad
  import sha_const::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [1:0]        Mode,
  sha_512_pad_if.slave      in_if,
  output logic [1023:0]     Data,
  output logic [127:0]      Index,
  output logic [1:0]        Operation,
  output logic              Enable,
  input  logic              Ready,
  output logic              Done
);

  pad_state_t       state;
  logic [4:0]       word_cnt;        // next word slot in the block, 0..16
  logic [127:0]     msg_len;         // message length in bits, wraps mod 2^128
  logic             marker_pending;  // message ended on a word boundary, 0x80 not yet written
  logic             len_pending;     // length did not fit; needs a following block
  logic             final_blk;       // block in flight carries the length
  logic [15:0][63:0] blk;
  logic [3:0]       last_bytes;

  assign Data           = blk;
  assign in_if.In_ready = (state == FILL);
  assign last_bytes     = clamp_bytes(in_if.In_bytes);

  // Keep the n leading bytes of w and place the 0x80 marker right after them.
  // Only called with n < 8, so the marker always lands inside the word.
  function automatic logic [63:0] pad_last_word(input logic [63:0] w,
                                                input logic [3:0]  n);
    logic [63:0] keep;
    logic [63:0] mark;
    if (n == 4'd0)
      keep = '0;
    else
      keep = ~64'd0 << (7'd64 - {n, 3'b000});
    mark = 64'h80 << (6'd56 - {n[2:0], 3'b000});
    return (w & keep) | mark;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      word_cnt       <= '0;
      msg_len        <= '0;
      marker_pending <= 1'b0;
      len_pending    <= 1'b0;
      final_blk      <= 1'b0;
      blk            <= '0;
      Index          <= '0;
      Operation      <= '0;
      Enable         <= 1'b0;
      Done           <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            word_cnt       <= '0;
            Index          <= '0;
            msg_len        <= '0;
            marker_pending <= 1'b0;
            len_pending    <= 1'b0;
            final_blk      <= 1'b0;
            Operation      <= Mode;
            state          <= FILL;
          end
        end

        FILL: begin
          if (in_if.In_valid) begin
            word_cnt <= word_cnt + 5'd1;
            // 8*n bits; for a full word this is 64 like any other word
            msg_len  <= msg_len + {121'd0, (in_if.In_last ? last_bytes : 4'd8), 3'b000};
            if (in_if.In_last) begin
              if (last_bytes == 4'd8) begin
                blk[word_cnt[3:0]] <= in_if.In_data;
                marker_pending     <= 1'b1;
              end else begin
                blk[word_cnt[3:0]] <= pad_last_word(in_if.In_data, last_bytes);
              end
              state <= PAD;
            end else begin
              blk[word_cnt[3:0]] <= in_if.In_data;
              if (word_cnt == BLOCK_WORDS - 5'd1) begin
                Enable <= 1'b1;
                state  <= SEND;
              end
            end
          end
        end

        PAD: begin
          if (word_cnt == BLOCK_WORDS) begin
            // No room for the length here; it goes into the next block.
            len_pending <= 1'b1;
            Enable      <= 1'b1;
            state       <= SEND;
          end else if (word_cnt == {1'b0, LEN_HI_POS} && !marker_pending) begin
            state <= LEN;
          end else begin
            blk[word_cnt[3:0]] <= marker_pending ? MARKER_WORD : 64'd0;
            marker_pending     <= 1'b0;
            word_cnt           <= word_cnt + 5'd1;
          end
        end

        LEN: begin
          blk[LEN_HI_POS] <= msg_len[127:64];
          blk[LEN_LO_POS] <= msg_len[63:0];
          final_blk       <= 1'b1;
          len_pending     <= 1'b0;
          Enable          <= 1'b1;
          state           <= SEND;
        end

        SEND: begin
          Enable <= 1'b0;
          state  <= WAIT;
        end

        WAIT: begin
          if (Ready) begin
            Index    <= Index + 128'd1;
            word_cnt <= '0;
            if (final_blk) begin
              Done  <= 1'b1;
              state <= IDLE;
            end else if (len_pending || marker_pending) begin
              state <= PAD;
            end else begin
              state <= FILL;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_512_pad.sv
// -----------------------------------------------------------------------------
// tb_sha_512_pad : directed and randomized bench for sha_512_pad.
// Expected blocks come from a byte-level SHA-512 padding model (message bytes,
// 0x80, zero fill to 112 mod 128, 128-bit big-endian bit length).
// -----------------------------------------------------------------------------
module tb_sha_512_pad;
  import sha_const::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Start = 1'b0;
  logic [1:0]    Mode = 2'd0;
  logic [1023:0] Data;
  logic [127:0]  Index;
  logic [1:0]    Operation;
  logic          Enable;
  logic          Ready = 1'b0;
  logic          Done;

  sha_512_pad_if in_if ();

  sha_512_pad dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Mode      (Mode),
    .in_if     (in_if),
    .Data      (Data),
    .Index     (Index),
    .Operation (Operation),
    .Enable    (Enable),
    .Ready     (Ready),
    .Done      (Done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor: capture blocks, watch protocol rules ----------
  logic [1023:0] cap_data[$];
  logic [127:0]  cap_idx[$];
  logic [1:0]    cap_op[$];
  logic [1023:0] saved[$];
  logic [1023:0] stab_data;
  logic [127:0]  stab_idx;
  logic [1:0]    stab_op;
  int  done_cnt = 0;
  int  en_cnt   = 0;
  bit  in_wait = 0, prev_en = 0;
  bit  bad_ready = 0, bad_overlap = 0, bad_en_len = 0, bad_stable = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) in_wait = 0;
    if (Enable) begin
      cap_data.push_back(Data);
      cap_idx.push_back(Index);
      cap_op.push_back(Operation);
      stab_data = Data;
      stab_idx  = Index;
      stab_op   = Operation;
      en_cnt++;
      in_wait = 1;
    end
    if (Done) done_cnt++;
    if (Enable && Done) bad_overlap = 1;
    if (Enable && prev_en) bad_en_len = 1;
    prev_en = Enable;
    if (Ready) in_wait = 0;
    else if (in_wait && !Enable) begin
      if (in_if.In_ready) bad_ready = 1;
      if (Data !== stab_data || Index !== stab_idx || Operation !== stab_op) bad_stable = 1;
    end
  end

  // ---------------- core stand-in: Ready after ready_delay cycles ----------
  int ready_delay = 2;
  always begin
    @(negedge clk);
    if (Enable) begin
      repeat (ready_delay) @(negedge clk);
      Ready = 1'b1;
      @(negedge clk);
      Ready = 1'b0;
    end
  end

  // ---------------- reference model ----------------------------------------
  logic [63:0]   words[$];
  logic [1023:0] exp_blocks[$];

  task automatic build_expected(input int last_field);
    byte unsigned msg[$];
    logic [127:0]  bitlen;
    logic [1023:0] b_v;
    int n;
    exp_blocks.delete();
    for (int w = 0; w < words.size(); w++) begin
      n = (w == words.size() - 1) ? ((last_field > 8) ? 8 : last_field) : 8;
      for (int k = 0; k < n; k++) msg.push_back(words[w][63 - 8*k -: 8]);
    end
    bitlen = 128'(msg.size()) * 128'd8;
    msg.push_back(8'h80);
    while (msg.size() % 128 != 112) msg.push_back(8'h00);
    for (int k = 15; k >= 0; k--) msg.push_back(bitlen[8*k +: 8]);
    for (int b = 0; b < msg.size() / 128; b++) begin
      b_v = '0;
      for (int w = 0; w < 16; w++)
        for (int k = 0; k < 8; k++)
          b_v[w*64 + 63 - 8*k -: 8] = msg[b*128 + w*8 + k];
      exp_blocks.push_back(b_v);
    end
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic fill_random(input int n);
    words.delete();
    repeat (n) words.push_back({$urandom, $urandom});
  endtask

  task automatic start_msg(input logic [1:0] m);
    @(negedge clk);
    Mode  = m;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic send_stream(input int last_field, input bit has_last,
                             input bit rand_valid, input bit poke_start);
    int i = 0;
    int guard = 0;
    while (i < words.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      in_if.In_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_if.In_data  = words[i];
      in_if.In_last  = has_last && (i == words.size() - 1);
      in_if.In_bytes = in_if.In_last ? 4'(last_field) : 4'($urandom_range(0, 15));
      if (poke_start) begin
        Start = 1'($urandom_range(0, 1));
        Mode  = 2'($urandom_range(0, 3));
      end
      if (in_if.In_valid && in_if.In_ready) begin
        @(posedge clk);
        i++;
      end
    end
    @(negedge clk);
    in_if.In_valid = 1'b0;
    in_if.In_last  = 1'b0;
    Start          = 1'b0;
    chk("stream_accepted", 128'(i), 128'(words.size()));
  endtask

  task automatic run_msg(input string name, input logic [1:0] m, input int last_field,
                         input bit rand_valid, input bit poke_start);
    int target;
    int c = 0;
    int nb;
    build_expected(last_field);
    cap_data.delete(); cap_idx.delete(); cap_op.delete();
    target = done_cnt + 1;
    start_msg(m);
    send_stream(last_field, 1'b1, rand_valid, poke_start);
    while (done_cnt < target && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({name, " done"}, 128'(done_cnt), 128'(target));
    repeat (4) @(negedge clk);
    chk({name, " done_once"}, 128'(done_cnt), 128'(target));
    chk({name, " blocks"}, 128'(cap_data.size()), 128'(exp_blocks.size()));
    nb = (cap_data.size() < exp_blocks.size()) ? cap_data.size() : exp_blocks.size();
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < 16; w++)
        chk($sformatf("%s blk%0d word%0d", name, b, w),
            128'(cap_data[b][w*64 +: 64]), 128'(exp_blocks[b][w*64 +: 64]));
      chk($sformatf("%s blk%0d index", name, b), cap_idx[b], 128'(b));
      chk($sformatf("%s blk%0d op", name, b), 128'(cap_op[b]), 128'(m));
    end
    saved = cap_data;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, " in_ready"},  128'(in_if.In_ready), 128'(0));
    chk({name, " enable"},    128'(Enable),         128'(0));
    chk({name, " done"},      128'(Done),           128'(0));
    chk({name, " index"},     Index,                128'(0));
    chk({name, " operation"}, 128'(Operation),      128'(0));
    chk({name, " data_zero"}, 128'(|Data),          128'(0));
    chk({name, " state"},     128'(dut.state),      128'(IDLE));
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    int en_before;
    int c;
    in_if.In_valid = 1'b0;
    in_if.In_data  = '0;
    in_if.In_last  = 1'b0;
    in_if.In_bytes = '0;

    // reset state
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // "abc"
    words.delete();
    words.push_back(64'h6162_6300_0000_0000);
    ready_delay = 2;
    run_msg("abc", 2'd3, 3, 1'b0, 1'b0);
    if (saved.size() > 0) begin
      chk("abc word0 const",  128'(saved[0][63:0]),     128'(64'h6162_6380_0000_0000));
      chk("abc word15 const", 128'(saved[0][1023:960]), 128'(64'h18));
    end

    // empty message, random junk in the word
    fill_random(1);
    run_msg("empty", 2'd0, 0, 1'b0, 1'b0);
    if (saved.size() > 0) begin
      chk("empty word0 const",  128'(saved[0][63:0]),     128'(MARKER_WORD));
      chk("empty word15 const", 128'(saved[0][1023:960]), 128'(0));
    end

    // 14 full words, marker spills into word 14, length into block 1
    fill_random(14);
    run_msg("w14", 2'd2, 8, 1'b0, 1'b0);
    if (saved.size() > 1) begin
      chk("w14 b0 word14 const", 128'(saved[0][959:896]),  128'(MARKER_WORD));
      chk("w14 b1 word15 const", 128'(saved[1][1023:960]), 128'(64'h380));
    end

    // 17 words, bursty valid, slow core
    fill_random(17);
    ready_delay = 81;
    run_msg("w17_slow", 2'd1, 8, 1'b1, 1'b0);

    // oversize byte count on the last word
    fill_random(5);
    ready_delay = 3;
    run_msg("bytes_gt8", 2'd3, 13, 1'b1, 1'b0);

    // randomized messages with Start/Mode noise while streaming
    for (int r = 0; r < 8; r++) begin
      fill_random($urandom_range(1, 34));
      ready_delay = $urandom_range(1, 6);
      run_msg($sformatf("rand%0d", r), 2'($urandom_range(0, 3)),
              $urandom_range(0, 15), 1'b1, 1'b1);
    end

    // reset while waiting on block 0
    fill_random(16);
    ready_delay = 81;
    start_msg(2'd3);
    send_stream(0, 1'b0, 1'b0, 1'b0);
    c = 0;
    while (en_cnt == 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero_outputs("post_reset");
    en_before = en_cnt;
    repeat (120) @(negedge clk);
    chk("post_reset no_enable", 128'(en_cnt), 128'(en_before));
    chk("post_reset idle", 128'(dut.state), 128'(IDLE));

    // normal operation after reset
    ready_delay = 2;
    fill_random(3);
    run_msg("after_reset", 2'd2, 5, 1'b1, 1'b0);

    // protocol rules observed throughout
    chk("in_ready_low_in_wait", 128'(bad_ready),   128'(0));
    chk("enable_done_overlap",  128'(bad_overlap), 128'(0));
    chk("enable_one_cycle",     128'(bad_en_len),  128'(0));
    chk("outputs_stable",       128'(bad_stable),  128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
